// File: rtl/step_decoder_pkg.sv
// step_pkg: shared step width, named control-unit steps and one-hot helper
package step_pkg;
  localparam int STEPS_DEF = 4;
  localparam int STEP_W = $clog2(STEPS_DEF);
  localparam int MAX_OH = 64;
  typedef enum logic [STEP_W-1:0] {T0, T1, T2, T3} step_e;
  function automatic logic [MAX_OH-1:0] onehot(input int unsigned idx);
    onehot = (idx < MAX_OH) ? ({{(MAX_OH-1){1'b0}}, 1'b1} << idx) : '0;
  endfunction
endpackage

// File: rtl/step_decoder_if.sv
// step_decoder_if: sequencer controls, select code and decoded outputs (Err present with STEP_DECODER_ERR_EN)
interface step_decoder_if #(
  parameter int W_BITS = 3,
  parameter int N_OUT = 8,
  parameter int STEPS = 4
);
  logic run;
  logic done;
  logic clear;
  logic hold;
  logic e;
  logic [W_BITS-1:0] w;
  logic [0:STEPS-1] tstep;
  logic [0:N_OUT-1] y;
  logic busy;
`ifdef STEP_DECODER_ERR_EN
  logic err;
  modport master(output run, done, clear, hold, e, w, input tstep, y, busy, err);
  modport slave(input run, done, clear, hold, e, w, output tstep, y, busy, err);
`else
  modport master(output run, done, clear, hold, e, w, input tstep, y, busy);
  modport slave(input run, done, clear, hold, e, w, output tstep, y, busy);
`endif
endinterface

// File: rtl/step_decoder_onehot_dec.sv
// onehot_dec: combinational index-to-one-hot converter, bit k set when idx == k and en is high
module onehot_dec
  import step_pkg::*;
#(
  parameter int IW = 3,
  parameter int N = 8
) (
  input  logic          en,
  input  logic [IW-1:0] idx,
  output logic [0:N-1]  y
);
  logic [N-1:0] oh;
  // out-of-range indices leave every bit clear
  always_comb begin
    oh = N'(onehot(32'(idx)));
    for (int k = 0; k < N; k++) y[k] = en & oh[k];
  end
endmodule

// File: rtl/step_decoder.sv
// step_decoder: one-hot timestep sequencer plus registered enable-gated select decoder; STEP_DECODER_ERR_EN adds Err
module step_decoder
  import step_pkg::*;
#(
  parameter int W_BITS = 3,
  parameter int N_OUT = 8,
  parameter int STEPS = 4
) (
  input logic clk,
  input logic rst,
  step_decoder_if.slave bus
);
  localparam int SW = $clog2(STEPS);
  logic [SW-1:0] s_q, s_d;
  logic [0:N_OUT-1] y_q, y_d;
  // next step: clear, then hold, then idle start, then early finish, then wrap/advance
  always_comb
    s_d = bus.clear ? SW'(T0) :
          bus.hold ? s_q :
          (s_q == '0) ? (bus.run ? SW'(T1) : SW'(T0)) :
          bus.done ? SW'(T0) :
          (32'(s_q) == STEPS - 1) ? SW'(T0) : s_q + 1'b1;
  onehot_dec #(.IW(SW), .N(STEPS)) u_tstep (.en(1'b1), .idx(s_q), .y(bus.tstep));
  onehot_dec #(.IW(W_BITS), .N(N_OUT)) u_y (.en(bus.e), .idx(bus.w), .y(y_d));
  assign bus.busy = |s_q;
  assign bus.y = y_q;
`ifdef STEP_DECODER_ERR_EN
  logic err_q, err_d;
  // enabled but nothing decoded means the code was out of range
  always_comb err_d = bus.e & ~|y_d;
  assign bus.err = err_q;
  // error flag registered alongside Y
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
`endif
  // step index and decoder output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_q <= '0;
      y_q <= '0;
    end else begin
      s_q <= s_d;
      y_q <= y_d;
    end
endmodule
